aclk_key_entry: RTL
===================

ACLK_KEY_ENTRY -- requirements
Module: aclk_key_entry

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: one_second  in  1  one-cycle strobe, once per second.
REQ-004 SHALL have port: key  in  4  key code: 0-9 digit, 10 ALARM, 11 TIME, 12-15 unused.
REQ-005 SHALL have port: key_valid  in  1  one-cycle strobe qualifying key.
REQ-006 SHALL have ports: key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  out  4 each  entered-digit buffer, BCD.
REQ-007 SHALL have port: load_new_a  out  1  one-cycle pulse, load buffer as alarm time.
REQ-008 SHALL have port: load_new_c  out  1  one-cycle pulse, load buffer as current time.
REQ-009 SHALL have port: show_a  out  1  display selects alarm time.
REQ-010 SHALL have port: show_new_time  out  1  display selects key buffer.
REQ-011 SHALL have port: entry_error  out  1  one-cycle pulse, rejected entry.
REQ-012 SHALL have parameter: TIMEOUT, default 10, idle seconds before entry/alarm view is abandoned.

Function
REQ-013 SHALL implement FSM states IDLE, ENTRY, SHOW_ALARM; all outputs registered.
REQ-014 SHALL ignore key_valid with key 12-15 in every state: no state, buffer or timer change.
REQ-015 Digit key (0-9), any state: buffer shifts left (ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key) next cycle; digit count +1, saturating at 4; timer cleared; next state ENTRY.
REQ-016 A digit in SHOW_ALARM SHALL drop show_a and enter ENTRY with count 1.
REQ-017 show_new_time SHALL be 1 exactly while in ENTRY; show_a SHALL be 1 exactly while in SHOW_ALARM.
REQ-018 ALARM key in IDLE -> SHOW_ALARM, timer cleared; ALARM key in SHOW_ALARM -> IDLE.
REQ-019 TIME key in IDLE or SHOW_ALARM SHALL return to/stay in IDLE with no pulses.
REQ-020 ALARM or TIME key in ENTRY with count==4 and buffer valid: load_new_a (ALARM) or load_new_c (TIME) pulses the cycle after capture, buffer held that cycle, then IDLE.
REQ-021 ALARM or TIME key in ENTRY with count<4 or buffer invalid: entry_error pulses the cycle after capture, no load pulse, then IDLE.
REQ-022 Buffer valid iff ms_hr<=2, ls_hr<=9, (ms_hr==2 -> ls_hr<=3), ms_min<=5, ls_min<=9; checked on buffer contents at the commit key.
REQ-023 Timer: 4-bit counter, increments on one_second in ENTRY or SHOW_ALARM; reaching TIMEOUT -> IDLE next cycle, no load/error pulse.
REQ-024 key_valid and one_second in same cycle: key processed, timer cleared, one_second discarded.
REQ-025 On every entry into IDLE the buffer and digit count SHALL clear to 0 one cycle after any load pulse.
REQ-026 load_new_a, load_new_c, entry_error SHALL be mutually exclusive and never asserted two consecutive cycles.
REQ-027 Timer SHALL hold at 0 in IDLE.

Reset
REQ-028 reset high at a clock edge: state IDLE, buffer 0000, count 0, timer 0, all pulses and show_a/show_new_time 0.
REQ-029 reset SHALL override simultaneous key_valid/one_second; an in-progress entry is discarded with no pulse.

Verification
REQ-030 Keys 1,2,3,4 then ALARM -> buffer 1,2,3,4, show_new_time 1 during entry, load_new_a single pulse, then IDLE with buffer 0000.
REQ-031 Keys 2,4,0,0 then TIME -> entry_error pulse (24:00 invalid), no load_new_c; keys 2,3,5,9 then TIME -> load_new_c pulse.
REQ-032 Keys 1,2 then ALARM -> entry_error pulse; keys 9,8,1,2,3,4 then TIME -> buffer 1,2,3,4, load_new_c pulse.
REQ-033 Key 5 then 10 one_second strobes without keys -> IDLE after 10th strobe, buffer 0000, no pulses; key on same cycle as 9th strobe restarts count.
REQ-034 ALARM in IDLE -> show_a 1; 10 one_second strobes -> show_a 0; repeat, then digit 7 -> show_a 0, show_new_time 1, ls_min 7.
REQ-035 Keys 1,2 then reset asserted together with key 3 -> all outputs 0, buffer 0000; key 13 in IDLE -> no change.

Source files
------------

// File: rtl/aclk_key_entry.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_key_entry
//  Description : Alarm-clock keypad entry controller. Collects up to four BCD
//                digits into a shift buffer, commits them as alarm or current
//                time on ALARM/TIME, flags malformed entries, offers an alarm
//                view mode and abandons idle sessions after TIMEOUT seconds.
//  Revision    : 1.0  initial release
// ============================================================================
module aclk_key_entry #(
    parameter int TIMEOUT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_a,
    output logic       show_new_time,
    output logic       entry_error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_ENTRY      = 2'd1;
    localparam logic [1:0] c_SHOW_ALARM = 2'd2;

    localparam logic [3:0] c_KEY_ALARM  = 4'd10;
    localparam logic [3:0] c_KEY_TIME   = 4'd11;

    // Timer value that, together with one more strobe, ends the session.
    localparam logic [3:0] c_TIMER_LAST = 4'(TIMEOUT - 1);

    localparam logic [2:0] c_FULL_COUNT = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [3:0] r_ms_hr;
    logic [3:0] r_ls_hr;
    logic [3:0] r_ms_min;
    logic [3:0] r_ls_min;
    logic [2:0] r_count;
    logic [3:0] r_timer;

    logic       r_load_a;
    logic       r_load_c;
    logic       r_error;
    logic       r_show_a;
    logic       r_show_new;

    logic       w_load_a_nxt;
    logic       w_load_c_nxt;
    logic       w_error_nxt;

    // ------------------------------------------------------------------------
    // Key decode; codes 12-15 are treated exactly as if no key arrived
    // ------------------------------------------------------------------------
    logic w_key_digit;
    logic w_key_alarm;
    logic w_key_time;
    logic w_key_any;

    assign w_key_digit = key_valid && (key <= 4'd9);
    assign w_key_alarm = key_valid && (key == c_KEY_ALARM);
    assign w_key_time  = key_valid && (key == c_KEY_TIME);
    assign w_key_any   = w_key_digit || w_key_alarm || w_key_time;

    // ------------------------------------------------------------------------
    // Buffer range check: HH in 00..23, MM in 00..59
    // ------------------------------------------------------------------------
    logic w_buf_valid;

    assign w_buf_valid = (r_ms_hr <= 4'd2)
                      && (r_ls_hr <= 4'd9)
                      && ((r_ms_hr != 4'd2) || (r_ls_hr <= 4'd3))
                      && (r_ms_min <= 4'd5)
                      && (r_ls_min <= 4'd9);

    // Commit request and its outcome; only meaningful during ENTRY
    logic w_commit;
    logic w_commit_ok;

    assign w_commit    = (r_state == c_ENTRY) && (w_key_alarm || w_key_time);
    assign w_commit_ok = w_commit && (r_count == c_FULL_COUNT) && w_buf_valid;

    // A second strobe is only honoured when no key shares its cycle
    logic w_tick;
    logic w_timeout;

    assign w_tick    = one_second && !w_key_any && (r_state != c_IDLE);
    assign w_timeout = w_tick && (r_timer == c_TIMER_LAST);

    // ------------------------------------------------------------------------
    // Next-state and next-pulse decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_load_a_nxt = 1'b0;
        w_load_c_nxt = 1'b0;
        w_error_nxt  = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_key_digit) begin
                    w_state_nxt = c_ENTRY;
                end else if (w_key_alarm) begin
                    w_state_nxt = c_SHOW_ALARM;
                end
            end

            c_ENTRY: begin
                if (w_key_digit) begin
                    w_state_nxt = c_ENTRY;
                end else if (w_commit) begin
                    w_state_nxt  = c_IDLE;
                    w_load_a_nxt = w_commit_ok && w_key_alarm;
                    w_load_c_nxt = w_commit_ok && w_key_time;
                    w_error_nxt  = !w_commit_ok;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end

            c_SHOW_ALARM: begin
                if (w_key_digit) begin
                    w_state_nxt = c_ENTRY;
                end else if (w_key_alarm || w_key_time) begin
                    w_state_nxt = c_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered pulses and display selects, aligned with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_a   <= 1'b0;
            r_load_c   <= 1'b0;
            r_error    <= 1'b0;
            r_show_a   <= 1'b0;
            r_show_new <= 1'b0;
        end else begin
            r_load_a   <= w_load_a_nxt;
            r_load_c   <= w_load_c_nxt;
            r_error    <= w_error_nxt;
            r_show_a   <= (w_state_nxt == c_SHOW_ALARM);
            r_show_new <= (w_state_nxt == c_ENTRY);
        end
    end

    // Digit buffer and count: shift within a session, start fresh otherwise.
    // Outside ENTRY the buffer is cleared, which leaves the committed value
    // visible for exactly the cycle of the load pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ms_hr  <= 4'd0;
            r_ls_hr  <= 4'd0;
            r_ms_min <= 4'd0;
            r_ls_min <= 4'd0;
            r_count  <= 3'd0;
        end else if (w_key_digit) begin
            if (r_state == c_ENTRY) begin
                r_ms_hr  <= r_ls_hr;
                r_ls_hr  <= r_ms_min;
                r_ms_min <= r_ls_min;
                r_ls_min <= key;
                if (r_count != c_FULL_COUNT) begin
                    r_count <= r_count + 3'd1;
                end
            end else begin
                r_ms_hr  <= 4'd0;
                r_ls_hr  <= 4'd0;
                r_ms_min <= 4'd0;
                r_ls_min <= key;
                r_count  <= 3'd1;
            end
        end else if (r_state != c_ENTRY) begin
            r_ms_hr  <= 4'd0;
            r_ls_hr  <= 4'd0;
            r_ms_min <= 4'd0;
            r_ls_min <= 4'd0;
            r_count  <= 3'd0;
        end
    end

    // Inactivity timer: any accepted key restarts it, IDLE pins it at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= 4'd0;
        end else if (w_key_any || (r_state == c_IDLE) || w_timeout) begin
            r_timer <= 4'd0;
        end else if (w_tick) begin
            r_timer <= r_timer + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign key_ms_hr     = r_ms_hr;
    assign key_ls_hr     = r_ls_hr;
    assign key_ms_min    = r_ms_min;
    assign key_ls_min    = r_ls_min;
    assign load_new_a    = r_load_a;
    assign load_new_c    = r_load_c;
    assign entry_error   = r_error;
    assign show_a        = r_show_a;
    assign show_new_time = r_show_new;

endmodule
`default_nettype wire
